regfile_multiport: RTL

- Parametrised successor to the 32x32, 2-read/1-write register file used by the single-cycle CPU datapath.
- Adds configurable width, depth, number of read ports and number of write ports, with deterministic write-port priority, optional write-to-read bypass, optional hardwired zero register and synchronous clear.
- Sits between decode and execute. Also serves as the base for the pipelined CPU, which needs a same-cycle write-then-read bypass and a second write port for load results.

---
 rtl/regfile_pkg.sv | 51 +++++
 rtl/regfile_read_port.sv | 64 ++++++
 rtl/regfile_multiport.sv | 108 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, types and the write-port arbitration function for the
// multiport register file.
//
// Contents:
//   DEF_*      default geometry used by regfile_multiport
//   MAX_*      upper bounds of the supported configuration space
//   wen_t      write enables widened to the maximum number of write ports
//   waddr_t    write addresses widened to the maximum address width
//   win_t      result of write arbitration for one address (hit + port index)
//   win_port   returns the write port that owns a given address this cycle
package regfile_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_REGS   = 32;
   localparam int DEF_NUM_READ   = 2;
   localparam int DEF_NUM_WRITE  = 1;

   localparam int MAX_NUM_REGS   = 256;
   localparam int MAX_NUM_READ   = 8;
   localparam int MAX_WRITE      = 4;
   localparam int MAX_AW         = 8;
   localparam int WIDX_W         = 2;

   typedef logic [MAX_WRITE-1:0]             wen_t;
   typedef logic [MAX_WRITE-1:0][MAX_AW-1:0] waddr_t;

   typedef struct packed {
      logic              hit;
      logic [WIDX_W-1:0] idx;
   } win_t;

   // Scanning upward and letting each later match overwrite the result gives
   // highest-numbered-port-wins. The enable is tested together with the
   // address match, so an unknown enable on a port can only ever affect the
   // address that port is pointing at.
   function automatic win_t win_port(input wen_t              we,
                                     input waddr_t            waddr,
                                     input logic [MAX_AW-1:0] addr,
                                     input int                num_write);
      win_t w;
      w = '0;
      for (int k = 0; k < MAX_WRITE; k++) begin
         if (k < num_write && we[k] && waddr[k] == addr) begin
            w.hit = 1'b1;
            w.idx = WIDX_W'(k);
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port of the multiport register file.
//
// Ports:
//   reset  in   synchronous reset of the parent; suppresses bypass while high
//   raddr  in   read address
//   mem    in   full storage array, register i in mem[i]
//   we     in   write enables, widened to MAX_WRITE
//   waddr  in   write addresses, widened to MAX_WRITE x MAX_AW
//   wdata  in   write data, widened to MAX_WRITE entries
//   rdata  out  read data
//
// Priority of the result, lowest to highest: storage mux, bypass of the
// winning write port, forced zero for out-of-range or hardwired-zero reads.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int NUM_WRITE  = DEF_NUM_WRITE,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS),
   parameter int BYPASS     = 0,
   parameter int ZERO_REG   = 1
) (
   input  logic                                 reset,
   input  logic [ADDR_WIDTH-1:0]                raddr,
   input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  mem,
   input  wen_t                                 we,
   input  waddr_t                               waddr,
   input  logic [MAX_WRITE-1:0][DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0]                rdata
);

   logic [MAX_AW-1:0] addr_ext;
   logic              in_range;
   logic              is_zero;
   win_t              win;

   always_comb begin
      addr_ext = MAX_AW'(raddr);
      in_range = (int'(addr_ext) < NUM_REGS);
      is_zero  = (ZERO_REG != 0) && (addr_ext == '0);
      win      = win_port(we, waddr, addr_ext, NUM_WRITE);

      rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_ext == MAX_AW'(i)) begin
            rdata = mem[i];
         end
      end

      if ((BYPASS != 0) && !reset && win.hit && in_range) begin
         rdata = wdata[win.idx];
      end

      if (!in_range || is_zero) begin
         rdata = '0;
      end
   end

   // With BYPASS=0 the write-side inputs have no effect on the result.
   logic unused_bypass_inputs;
   assign unused_bypass_inputs = ^{reset, we, waddr, wdata};

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file: NUM_WRITE write ports with
// highest-port-wins arbitration, NUM_READ independent combinational read
// ports, optional write-to-read bypass and optional hardwired zero register.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high clear of every register;
//                       writes in the reset cycle are discarded
//   RegWrite       in   per-port write enable
//   WriteRegister  in   write addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   WriteData      in   write data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   ReadRegister   in   read addresses, packed like WriteRegister
//   ReadData       out  read data, packed like WriteData
module regfile_multiport
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int NUM_READ   = DEF_NUM_READ,
   parameter int NUM_WRITE  = DEF_NUM_WRITE,
   parameter int BYPASS     = 0,
   parameter int ZERO_REG   = 1,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_WRITE-1:0]           RegWrite,
   input  logic [NUM_WRITE*ADDR_WIDTH-1:0] WriteRegister,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] WriteData,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister,
   output logic [NUM_READ*DATA_WIDTH-1:0] ReadData
);

   if (NUM_REGS < 2 || NUM_REGS > MAX_NUM_REGS) begin : g_bad_regs
      $error("regfile_multiport: NUM_REGS out of range");
   end
   if (NUM_READ < 1 || NUM_READ > MAX_NUM_READ) begin : g_bad_read
      $error("regfile_multiport: NUM_READ out of range");
   end
   if (NUM_WRITE < 1 || NUM_WRITE > MAX_WRITE) begin : g_bad_write
      $error("regfile_multiport: NUM_WRITE out of range");
   end

   // Write ports widened to the package maxima so the arbitration function
   // is shared unchanged by the storage and by every read port.
   wen_t                                 we_ext;
   waddr_t                               waddr_ext;
   logic [MAX_WRITE-1:0][DATA_WIDTH-1:0] wdata_ext;

   always_comb begin
      we_ext    = '0;
      waddr_ext = '0;
      wdata_ext = '0;
      for (int k = 0; k < NUM_WRITE; k++) begin
         we_ext[k]                     = RegWrite[k];
         waddr_ext[k][ADDR_WIDTH-1:0]  = WriteRegister[k*ADDR_WIDTH +: ADDR_WIDTH];
         wdata_ext[k]                  = WriteData[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_q;
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem_d;

   // Each register looks up which port (if any) owns it this cycle.
   // Out-of-range addresses never match a register index and fall away.
   always_comb begin : c_store
      win_t win;
      win   = '0;
      mem_d = mem_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         win = win_port(we_ext, waddr_ext, MAX_AW'(i), NUM_WRITE);
         if (win.hit && !((ZERO_REG != 0) && (i == 0))) begin
            mem_d[i] = wdata_ext[win.idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      regfile_read_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .NUM_REGS   (NUM_REGS),
         .NUM_WRITE  (NUM_WRITE),
         .ADDR_WIDTH (ADDR_WIDTH),
         .BYPASS     (BYPASS),
         .ZERO_REG   (ZERO_REG)
      ) u_rd (
         .reset (reset),
         .raddr (ReadRegister[p*ADDR_WIDTH +: ADDR_WIDTH]),
         .mem   (mem_q),
         .we    (we_ext),
         .waddr (waddr_ext),
         .wdata (wdata_ext),
         .rdata (ReadData[p*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   a_regwrite_known : assert property (@(posedge clk) disable iff (reset)
                                       !$isunknown(RegWrite));

endmodule
